m_axi_reg_master: RTL
=====================

Name: m_axi_reg_master

Overview:
- Single-outstanding AXI4-Lite-with-ID master: the initiator end of the register-slave interface (`s_axi_reg`).
- Accepts one write or read command from a local user port.
- Runs the matching AXI channel handshakes: AW+W then B, or AR then R.
- Returns a one-entry response to the user, so firmware-style sequencers and integration benches no longer hand-drive AXI valid/ready timing.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- ID_W, 4, transaction ID width

Ports:
- clk  in  1  system clock, all logic on rising edge
- areset  in  1  asynchronous, active-low reset
- cmd_valid_i  in  1  user command valid
- cmd_ready_o  out  1  master idle, command accepted when valid&ready
- cmd_write_i  in  1  1=write, 0=read
- cmd_addr_i  in  ADDR_W  target address
- cmd_wdata_i  in  DATA_W  write data
- cmd_wstrb_i  in  DATA_W/8  write byte strobes
- rsp_valid_o  out  1  response held valid
- rsp_ready_i  in  1  user consumes response
- rsp_write_o  out  1  response belongs to a write
- rsp_rdata_o  out  DATA_W  read data (0 for writes)
- rsp_resp_o  out  2  AXI resp code, or 2'b10 forced on ID mismatch
- rsp_idmis_o  out  1  returned bid/rid differed from issued ID
- awid_o  out  ID_W
- awaddr_o  out  ADDR_W
- awvalid_o  out  1
- awready_i  in  1
- wdata_o  out  DATA_W
- wstrb_o  out  DATA_W/8
- wvalid_o  out  1
- wready_i  in  1
- bid_i  in  ID_W
- bresp_i  in  2
- bvalid_i  in  1
- bready_o  out  1
- arid_o  out  ID_W
- araddr_o  out  ADDR_W
- arvalid_o  out  1
- arready_i  in  1
- rid_i  in  ID_W
- rdata_i  in  DATA_W
- rresp_i  in  2
- rvalid_i  in  1
- rready_o  out  1

Behaviour:
- Reset (areset=0, async):
  - state=IDLE.
  - All valid/ready outputs 0 except cmd_ready_o=1.
  - All address/data/id/strb/rsp outputs 0.
  - id_cnt=0.
- States and transitions:
  - IDLE: cmd_ready_o=1. On cmd_valid_i, latch addr/wdata/wstrb/write. Write -> WR_REQ, read -> RD_ADDR. cmd_ready_o drops the next cycle.
  - WR_REQ: awvalid_o and wvalid_o both asserted on entry, same cycle, with awid_o=id_cnt. Each valid deasserts the cycle after its own handshake (valid&ready at a posedge). AW and W complete independently, in either order or together. When both are done -> WR_RESP.
  - WR_RESP: bready_o=1. On bvalid_i, capture bresp_i and compare bid_i with the issued ID -> RSP.
  - RD_ADDR: arvalid_o=1, arid_o=id_cnt. On arready_i -> RD_DATA.
  - RD_DATA: rready_o=1. On rvalid_i, capture rdata_i, rresp_i and the ID compare -> RSP.
  - RSP: rsp_valid_o=1, outputs stable. On rsp_ready_i -> IDLE and id_cnt increments (wraps at 2^ID_W-1 -> 0).
- Handshake rules:
  - Once a valid is asserted, it and its payload stay stable until its ready.
  - Master never deasserts a valid without a completed handshake.
  - bready_o/rready_o are only high in their wait state.
- ID mismatch: rsp_idmis_o=1 and rsp_resp_o=2'b10 (SLVERR), regardless of the returned resp.
- Minimum latencies:
  - Write: cmd accept -> rsp_valid_o in 3 cycles (AW/W ready same cycle, B next).
  - Read: 3 cycles.
- Boundaries:
  - A cmd_valid_i asserted outside IDLE is ignored (not latched).
  - awready_i/wready_i/bvalid_i/arready_i/rvalid_i arriving in the wrong state are ignored.
  - Reset asserted mid-transaction returns to the reset state immediately. The slave must be reset together with the master.
  - The user may hold rsp_ready_i high permanently; the response then lasts exactly one cycle.

Test Plan:
- Reset, then write 0xA3DD0000 <- 0xC2CCEE2E, wstrb=4'hF, slave AW/W ready immediately:
  - awvalid_o/wvalid_o high one cycle, awid_o=0.
  - bresp=0, bid=0 -> rsp_valid_o with rsp_write_o=1, rsp_resp_o=0.
  - id_cnt becomes 1.
- Write to 0xA3DD0001 with wready delayed 4 cycles after awready:
  - awvalid_o drops after its handshake; wvalid_o held stable 4 more cycles.
  - bready_o rises only after both handshakes.
- Read 0xA3DD0001 after the preceding writes, arready delayed 2 cycles, rdata=0xC2AAEE2A, rid matches:
  - arvalid_o held 3 cycles, araddr_o stable.
  - rsp_rdata_o=0xC2AAEE2A, rsp_resp_o=0, rsp_idmis_o=0.
- Read where the slave returns rid=5 while arid_o=2:
  - rsp_idmis_o=1, rsp_resp_o=2'b10.
- Issue 17 back-to-back commands:
  - IDs run 0..15, then 0.
  - cmd_ready_o low from acceptance until response consumption.
  - A cmd_valid_i pulse during a busy state is never executed.
- Assert areset=0 while in WR_REQ with awvalid_o high:
  - All valids drop asynchronously, cmd_ready_o=1 after release, id_cnt=0.

Source files
------------

// File: rtl/m_axi_reg_master.sv
// Single-outstanding AXI4-Lite-with-ID master. It takes one user command, runs AW+W/B or AR/R,
// then holds a one-entry response until the user consumes it.
module m_axi_reg_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
) (
    input  logic                clk,
    input  logic                areset,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_write_i,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [DATA_W-1:0]   cmd_wdata_i,
    input  logic [DATA_W/8-1:0] cmd_wstrb_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic                rsp_write_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic [1:0]          rsp_resp_o,
    output logic                rsp_idmis_o,
    output logic [ID_W-1:0]     awid_o,
    output logic [ADDR_W-1:0]   awaddr_o,
    output logic                awvalid_o,
    input  logic                awready_i,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic                wvalid_o,
    input  logic                wready_i,
    input  logic [ID_W-1:0]     bid_i,
    input  logic [1:0]          bresp_i,
    input  logic                bvalid_i,
    output logic                bready_o,
    output logic [ID_W-1:0]     arid_o,
    output logic [ADDR_W-1:0]   araddr_o,
    output logic                arvalid_o,
    input  logic                arready_i,
    input  logic [ID_W-1:0]     rid_i,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic [1:0]          rresp_i,
    input  logic                rvalid_i,
    output logic                rready_o
);

    typedef enum logic [2:0] {StIdle, StWrReq, StWrResp, StRdAddr, StRdData, StRsp} state_e;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic [ID_W-1:0]       id_q, id_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  rsp_write_q;
    logic [DATA_W-1:0]     rsp_rdata_q;
    logic [1:0]            rsp_resp_q;
    logic                  rsp_idmis_q;
    logic                  latch_cmd, cap_b, cap_r;
    logic                  aw_hs, w_hs;

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        latch_cmd   = 1'b0;
        cap_b       = 1'b0;
        cap_r       = 1'b0;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        cmd_ready_o = 1'b0;
        awvalid_o   = 1'b0;
        wvalid_o    = 1'b0;
        bready_o    = 1'b0;
        arvalid_o   = 1'b0;
        rready_o    = 1'b0;
        rsp_valid_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    latch_cmd = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_write_i ? StWrReq : StRdAddr;
                end
            end
            StWrReq: begin
                // AW and W retire independently; each valid drops after its own handshake
                awvalid_o = ~aw_done_q;
                wvalid_o  = ~w_done_q;
                aw_hs     = ~aw_done_q & awready_i;
                w_hs      = ~w_done_q & wready_i;
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = StWrResp;
                end
            end
            StWrResp: begin
                bready_o = 1'b1;
                if (bvalid_i) begin
                    cap_b   = 1'b1;
                    state_d = StRsp;
                end
            end
            StRdAddr: begin
                arvalid_o = 1'b1;
                if (arready_i) begin
                    state_d = StRdData;
                end
            end
            StRdData: begin
                rready_o = 1'b1;
                if (rvalid_i) begin
                    cap_r   = 1'b1;
                    state_d = StRsp;
                end
            end
            StRsp: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    id_d    = id_q + {{(ID_W-1){1'b0}}, 1'b1};
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            id_q        <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
            rsp_idmis_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (latch_cmd) begin
                addr_q  <= cmd_addr_i;
                wdata_q <= cmd_wdata_i;
                wstrb_q <= cmd_wstrb_i;
            end
            // A returned ID that differs from the issued one overrides the slave's resp
            if (cap_b) begin
                rsp_write_q <= 1'b1;
                rsp_rdata_q <= '0;
                rsp_idmis_q <= (bid_i != id_q);
                rsp_resp_q  <= (bid_i != id_q) ? 2'b10 : bresp_i;
            end else if (cap_r) begin
                rsp_write_q <= 1'b0;
                rsp_rdata_q <= rdata_i;
                rsp_idmis_q <= (rid_i != id_q);
                rsp_resp_q  <= (rid_i != id_q) ? 2'b10 : rresp_i;
            end
        end
    end

    assign awid_o      = id_q;
    assign arid_o      = id_q;
    assign awaddr_o    = addr_q;
    assign araddr_o    = addr_q;
    assign wdata_o     = wdata_q;
    assign wstrb_o     = wstrb_q;
    assign rsp_write_o = rsp_write_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_resp_o  = rsp_resp_q;
    assign rsp_idmis_o = rsp_idmis_q;

endmodule
